// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock and decodes 11-bit frames.
// Good bytes go into a first-word-fall-through FIFO; frame and overflow errors are sticky.
module ps2_kb_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kb_clk_i,
    input  logic       kb_dat_i,
    input  logic       rd_i,
    input  logic       clr_err_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic [4:0] count_o,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [1:0]    kclk_sync_q, kdat_sync_q;
    logic          kclk_s, kdat_s;
    logic          kclk_f_q, kclk_f_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_c;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_c, ferr_ev_c;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d, ovf_q, ovf_d;
    logic          pop_c, full_c, wr_en_c, ovf_ev_c;

    assign kclk_s = kclk_sync_q[1];
    assign kdat_s = kdat_sync_q[1];

    // Glitch filter: the filtered clock flips only after FILTER_LEN samples of the new level
    always_comb begin
        flt_cnt_d = '0;
        kclk_f_d  = kclk_f_q;
        fall_c    = 1'b0;
        if (kclk_s != kclk_f_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                kclk_f_d = kclk_s;
                fall_c   = kclk_f_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    // Frame decoder with inter-edge timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = '0;
        push_c    = 1'b0;
        ferr_ev_c = 1'b0;
        if (state_q != S_IDLE && !fall_c) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_IDLE;
                ferr_ev_c = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (fall_c) begin
            case (state_q)
                S_IDLE: begin
                    if (!kdat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_d   = {kdat_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = kdat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (kdat_s && (^{shreg_q, par_q})) begin
                        push_c = 1'b1;
                    end else begin
                        ferr_ev_c = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; the registered head is computed from the post-update pointers
    always_comb begin
        pop_c    = rd_i && valid_q;
        full_c   = (count_q == CW'(FIFO_DEPTH));
        wr_en_c  = push_c && (!full_c || pop_c);
        ovf_ev_c = push_c && full_c && !pop_c;
        wr_ptr_d = wr_en_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !wr_en_c) begin
            count_d = count_q - CW'(1);
        end
        valid_d = (count_d != '0);
        data_d  = 8'h00;
        if (count_d != '0) begin
            if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
                data_d = shreg_q;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
        ferr_d = ferr_ev_c || (ferr_q && !clr_err_i);
        ovf_d  = ovf_ev_c || (ovf_q && !clr_err_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kclk_sync_q <= 2'b11;
            kdat_sync_q <= 2'b11;
            kclk_f_q    <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            kclk_sync_q <= {kclk_sync_q[0], kb_clk_i};
            kdat_sync_q <= {kdat_sync_q[0], kb_dat_i};
            kclk_f_q    <= kclk_f_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en_c) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign count_o     = count_q;
    assign frame_err_o = ferr_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: 1 MHz system clock, 12.5 kHz PS/2 clock, scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_ps2_kb_rx;

    localparam int HALF = 40;
    localparam int TMO  = 200;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_clk = 1'b1;
    logic       kb_dat = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overflow;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] sb[$];
    int         model_cnt = 0;

    ps2_kb_rx #(
        .FIFO_DEPTH    (DEPTH),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .kb_clk_i   (kb_clk),
        .kb_dat_i   (kb_dat),
        .rd_i       (rd),
        .clr_err_i  (clr_err),
        .data_o     (data),
        .valid_o    (valid),
        .count_o    (count),
        .frame_err_o(frame_err),
        .overflow_o (overflow)
    );

    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic p);
        return {1'b1, p, b, 1'b0};
    endfunction

    // Drives bits[0..n-1]; glitch_bit inserts a 3-cycle low pulse in that bit's high phase
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            kb_dat = bits[i];
            if (i == glitch_bit) begin
                repeat (HALF / 2) @(negedge clk);
                kb_clk = 1'b0;
                repeat (3) @(negedge clk);
                kb_clk = 1'b1;
                repeat (HALF / 2 - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            kb_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            kb_clk = 1'b1;
        end
        kb_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p, input int glitch_bit);
        send_bits(mkframe(b, p), 11, glitch_bit);
        if ((^{b, p}) == 1'b1 && model_cnt < DEPTH) begin
            sb.push_back(b);
            model_cnt++;
        end
    endtask

    task automatic read_one(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, 32'(valid), 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_data"}, 32'(data), 32'(exp));
            model_cnt--;
        end else begin
            check({tag, "_data_unexpected"}, 32'(data), 32'hFFFF_FFFF);
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single good frame then pop
        send_byte(8'h1C, 1'b0, -1);
        check("good_count", 32'(count), 32'd1);
        check("good_ferr", 32'(frame_err), 32'd0);
        read_one("good");
        check("pop_valid", 32'(valid), 32'd0);
        check("pop_data", 32'(data), 32'h00);

        // Bad parity sets sticky error, clr_err clears it
        send_byte(8'h1C, 1'b1, -1);
        check("par_ferr", 32'(frame_err), 32'd1);
        check("par_valid", 32'(valid), 32'd0);
        pulse_clr();
        check("clr_ferr", 32'(frame_err), 32'd0);

        // Overflow: nine good frames into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), ~^(8'(i)), -1);
        end
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(data), 32'h01);
        for (int i = 0; i < 8; i++) begin
            read_one("ovf_pop");
        end
        check("ovf_empty", 32'(valid), 32'd0);
        check("ovf_cnt0", 32'(count), 32'd0);
        pulse_clr();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Glitches in IDLE and mid-DATA must not be sampled as edges
        kb_clk = 1'b0;
        repeat (3) @(negedge clk);
        kb_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        send_byte(8'hF0, 1'b1, 4);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        check("glitch_count", 32'(count), 32'd1);
        read_one("glitch");

        // Timeout on a stalled frame
        send_bits(mkframe(8'hF0, 1'b1), 4, -1);
        check("tmo_early", 32'(frame_err), 32'd0);
        repeat (TMO) @(negedge clk);
        check("tmo_ferr", 32'(frame_err), 32'd1);
        check("tmo_valid", 32'(valid), 32'd0);
        pulse_clr();
        send_byte(8'hF0, 1'b1, -1);
        read_one("tmo_next");
        check("tmo_next_ferr", 32'(frame_err), 32'd0);

        // Reset mid-frame; the all-ones tail must be ignored
        send_bits(mkframe(8'h5A, 1'b1), 5, -1);
        do_reset();
        send_bits(11'h03F, 6, -1);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_ferr", 32'(frame_err), 32'd0);
        send_byte(8'h5A, 1'b1, -1);
        read_one("abort_next");
        check("final_empty", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive identical clk_i samples required to accept a kb_clk level change.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000, maximum clk_i cycles between kb_clk falling edges within a frame (200 us at 50 MHz).
REQ-004 SHALL have port clk_i input 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i input 1, synchronous active-high reset.
REQ-006 SHALL have port kb_clk_i input 1, raw PS/2 clock pin, asynchronous.
REQ-007 SHALL have port kb_dat_i input 1, raw PS/2 data pin, asynchronous.
REQ-008 SHALL have port rd_i input 1, pop request for the FIFO head.
REQ-009 SHALL have port clr_err_i input 1, clears the sticky error flags.
REQ-010 SHALL have port data_o output 8, FIFO head byte (first-word fall-through).
REQ-011 SHALL have port valid_o output 1, FIFO non-empty.
REQ-012 SHALL have port count_o output 5, FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 SHALL have port frame_err_o output 1, sticky start/parity/stop/timeout error.
REQ-014 SHALL have port overflow_o output 1, sticky flag: good frame dropped because FIFO full.

Function
REQ-015 SHALL pass kb_clk_i and kb_dat_i through two-flop synchronizers before any use.
REQ-016 SHALL change filtered kb_clk only after FILTER_LEN consecutive equal synchronized samples; shorter pulses ignored.
REQ-017 SHALL generate a one-cycle fall strobe on each filtered kb_clk 1->0 transition and sample synchronized kb_dat in that cycle.
REQ-018 SHALL implement FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on fall strobes.
REQ-019 IDLE: sampled 0 = start bit, go to DATA with bit counter 0; sampled 1 = ignored, remain IDLE.
REQ-020 DATA: shift 8 bits LSB first; after 8th bit go to PARITY.
REQ-021 PARITY: record bit; frame parity good when the 8 data bits plus parity bit contain an odd number of ones.
REQ-022 STOP: sampled 1 with good parity = good frame; otherwise set frame_err_o and drop byte; return to IDLE either way.
REQ-023 SHALL push a good frame's byte so valid_o/data_o reflect it within FILTER_LEN+4 clk_i cycles of the stop-bit kb_clk_i falling edge.
REQ-024 Outside IDLE, no fall strobe for TIMEOUT_CYCLES cycles: return to IDLE, set frame_err_o, discard partial byte.
REQ-025 Good frame while FIFO full and no pop that cycle: drop byte, set overflow_o, FIFO contents unchanged.
REQ-026 Good frame while full with pop in same cycle: perform both, accept byte, overflow_o not set, count_o unchanged.
REQ-027 rd_i with valid_o=1 SHALL pop the head in that cycle; rd_i with valid_o=0 SHALL be ignored with no pointer change.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count_o increments on push-only, decrements on pop-only, unchanged otherwise.
REQ-029 data_o SHALL be 8'h00 when valid_o=0.
REQ-030 clr_err_i SHALL clear frame_err_o and overflow_o next cycle; an error event in the same cycle wins (flag stays 1).

Reset
REQ-031 rst_i=1 SHALL force next edge: FSM IDLE, bit counter 0, timeout counter 0, FIFO empty, count_o=0, valid_o=0, data_o=8'h00, frame_err_o=0, overflow_o=0, filtered kb_clk=1, synchronizer flops=1.
REQ-032 Reset mid-frame SHALL abandon the frame; the remaining bits of that frame SHALL NOT produce a push (start bit rule: first 0 sampled after reset begins a new frame; the bench checks no byte appears from the tail of an abandoned frame with data bits all 1).
REQ-033 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 Send frame 0x1C, parity 0, stop 1 at 12.5 kHz -> valid_o=1, data_o=8'h1C, count_o=1, no error; rd_i pulse -> valid_o=0, data_o=8'h00.
REQ-035 Send 0x1C with parity 1 -> frame_err_o=1, valid_o=0; clr_err_i pulse -> frame_err_o=0.
REQ-036 Send nine good frames 0x01..0x09 with no reads (FIFO_DEPTH=8) -> count_o=8, overflow_o=1, data_o=8'h01; eight pops yield 0x01..0x08.
REQ-037 Inject 3-cycle low glitches on kb_clk_i during IDLE and mid-DATA -> no extra bit sampled; following frame 0xF0, parity 1 received correctly.
REQ-038 Send start plus 3 data bits then stop toggling -> frame_err_o=1 after TIMEOUT_CYCLES; next frame 0xF0 received as 8'hF0.
REQ-039 Assert rst_i after bit 4 of frame 0x5A, complete that frame with all remaining data bits, parity and stop at 1 -> no push, valid_o=0; next frame 0x5A, parity 1 received.
